fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction queue between the fetch stage and the decode stage. It replaces the single-entry fetch/decode pipeline register with a DEPTH-entry first-word-fall-through buffer. Fetch can run ahead while decode stalls, and a taken branch or jump in decode discards every queued instruction in one cycle. When the queue is empty it presents a NOP (all-zero instruction) to decode, so an empty queue behaves like a bubble.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction width
- PC_WIDTH, 32, width of the pc_plus_four field stored with each instruction
- DEPTH, 4, number of entries; power of two, minimum 2
- CNT_WIDTH, $clog2(DEPTH+1), width of count

Ports:
- clock  in  1  rising-edge clock, the only clock
- reset_n  in  1  asynchronous, active-low reset
- push  in  1  fetch presents a valid instruction this cycle
- instruction_F  in  DATA_WIDTH  instruction from fetch
- pc_plus_four_F  in  PC_WIDTH  pc+4 of instruction_F
- full  out  1  count == DEPTH; drives the fetch stall
- pop  in  1  decode consumes the head entry this cycle
- flush  in  1  taken branch or jump in decode; discard all entries
- valid_D  out  1  head entry is valid (count != 0)
- instruction_D  out  DATA_WIDTH  head instruction; 0 when empty
- pc_plus_four_D  out  PC_WIDTH  head pc+4; 0 when empty
- count  out  CNT_WIDTH  number of valid entries, 0..DEPTH
- overflow  out  1  sticky: push seen while full, not masked by pop, no flush

## Operation
- Storage: a circular buffer of DEPTH {pc_plus_four, instruction} pairs, a read pointer and a write pointer, each log2(DEPTH) bits, plus a registered count.
  - Both pointers wrap from DEPTH-1 to 0 with natural modulo arithmetic.
- The head is read combinationally from storage[rd_ptr] (first-word fall-through).
  - When count == 0, the outputs are forced to instruction_D = 0, pc_plus_four_D = 0 and valid_D = 0.
- Accept rules, evaluated at each rising edge:
  - pop_ok = pop & (count != 0)
  - push_ok = push & (count != DEPTH) & !flush
  - full depends on count only. A push when count == DEPTH is rejected even if pop_ok is set in the same cycle; there is no pass-through when full.
- State updates:
  - push_ok: write at wr_ptr, then wr_ptr += 1.
  - pop_ok: rd_ptr += 1.
  - count += push_ok - pop_ok.
- flush has priority over everything:
  - rd_ptr, wr_ptr and count all go to 0.
  - A same-cycle push and pop are both ignored.
  - The contents of storage are don't-care.
- overflow is set at an edge where push & full & !pop & !flush. It is cleared only by reset.
- pop while empty is ignored; no state changes and overflow is unaffected.
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - Pointers, count and overflow go to 0.
  - Outputs go to valid_D = 0, instruction_D = 0, pc_plus_four_D = 0, full = 0, count = 0, overflow = 0.
  - Storage is not reset.
  - A reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Timing
- Write-to-read latency is 1 cycle. A push accepted at edge k appears on instruction_D/valid_D right after edge k if the queue was empty.
- A pop accepted at edge k advances the head so the next entry, or the NOP, is visible after edge k.
- full, valid_D and count are registered-state decodes. They change only at clock edges or on asynchronous reset; they have no combinational path from push, pop or flush.
- A flush at edge k gives valid_D = 0 after edge k. The first post-flush push can be accepted at edge k+1.
- Throughput is one push and one pop per cycle in steady state when 0 < count < DEPTH.
- With DEPTH = 2, behaviour is identical apart from the wrap period; no special-casing.

## Test plan
- Reset and empty: hold reset_n = 0, then release with no push. Required: valid_D = 0, instruction_D = 0, count = 0, full = 0 for 10 cycles; pop pulses change nothing.
- Fill and drain, DEPTH = 4: push 0x20080001..0x20080004 with pc+4 = 4, 8, 12, 16 on consecutive cycles, pop held low. Required:
  - full = 1 and count = 4 after the 4th edge.
  - A 5th push (0x20080005) is dropped and sets overflow = 1.
  - Popping 4 times yields entries 1..4 in order, then valid_D = 0.
- Streaming with wrap: hold push and pop high for 20 cycles, data = cycle index. Required: count stays at 1, the output sequence equals the input delayed by 1, and both pointers wrap at least 4 times with no loss.
- Flush priority: with count = 3, assert flush + push (0xDEADBEEF) + pop in one cycle. Required:
  - count = 0 and valid_D = 0 next cycle; 0xDEADBEEF never appears.
  - A push of 0x00000020 on the next cycle is visible after 1 edge.
- Full with pop: with count = 4, assert push and pop together. Required: count = 3, the pushed word is rejected, and overflow stays 0.
- Async reset mid-stream: with count = 2, drop reset_n between clock edges. Required: valid_D = 0 and count = 0 immediately, before the next edge; overflow = 0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: fetch push side, decode pop/flush side and status.
// master drives requests (fetch + decode), slave is the queue itself.
interface fetch_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
);
  logic                  push;
  logic [DATA_WIDTH-1:0] instruction_F;
  logic [PC_WIDTH-1:0]   pc_plus_four_F;
  logic                  full;
  logic                  pop;
  logic                  flush;
  logic                  valid_D;
  logic [DATA_WIDTH-1:0] instruction_D;
  logic [PC_WIDTH-1:0]   pc_plus_four_D;
  logic [CNT_WIDTH-1:0]  count;
  logic                  overflow;

  modport master (
    output push, instruction_F, pc_plus_four_F, pop, flush,
    input  full, valid_D, instruction_D, pc_plus_four_D, count, overflow
  );

  modport slave (
    input  push, instruction_F, pc_plus_four_F, pop, flush,
    output full, valid_D, instruction_D, pc_plus_four_D, count, overflow
  );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry first-word-fall-through instruction queue between fetch and decode.
// An empty queue presents an all-zero NOP; flush discards every entry in one cycle.
module fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input logic         clock,
  input logic         reset_n,
  fetch_queue_if.slave fq
);
  localparam int PTR_WIDTH  = $clog2(DEPTH);
  localparam int WORD_WIDTH = PC_WIDTH + DATA_WIDTH;

  logic [WORD_WIDTH-1:0] storage [DEPTH];

  logic [PTR_WIDTH-1:0] rdPtrR, wrPtrR, rdPtrNext, wrPtrNext;
  logic [CNT_WIDTH-1:0] countR, countNext;
  logic                 overflowR, overflowNext;
  logic                 pushOk, popOk, fullS, emptyS;
  logic [WORD_WIDTH-1:0] headWord;

  assign fullS  = (countR == CNT_WIDTH'(DEPTH));
  assign emptyS = (countR == {CNT_WIDTH{1'b0}});
  // No pass-through when full: a same-cycle pop does not make room for the push.
  assign popOk  = fq.pop & ~emptyS;
  assign pushOk = fq.push & ~fullS & ~fq.flush;

  // State register: pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdPtrR    <= {PTR_WIDTH{1'b0}};
      wrPtrR    <= {PTR_WIDTH{1'b0}};
      countR    <= {CNT_WIDTH{1'b0}};
      overflowR <= 1'b0;
    end else begin
      rdPtrR    <= rdPtrNext;
      wrPtrR    <= wrPtrNext;
      countR    <= countNext;
      overflowR <= overflowNext;
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clock) begin
    if (pushOk) begin
      storage[wrPtrR] <= {fq.pc_plus_four_F, fq.instruction_F};
    end
  end

  // Next-state logic; flush overrides any same-cycle push or pop.
  always_comb begin
    rdPtrNext    = rdPtrR;
    wrPtrNext    = wrPtrR;
    countNext    = countR;
    overflowNext = overflowR | (fq.push & fullS & ~fq.pop & ~fq.flush);
    if (fq.flush) begin
      rdPtrNext = {PTR_WIDTH{1'b0}};
      wrPtrNext = {PTR_WIDTH{1'b0}};
      countNext = {CNT_WIDTH{1'b0}};
    end else begin
      if (pushOk) begin
        wrPtrNext = wrPtrR + PTR_WIDTH'(1);
      end else begin
        wrPtrNext = wrPtrR;
      end
      if (popOk) begin
        rdPtrNext = rdPtrR + PTR_WIDTH'(1);
      end else begin
        rdPtrNext = rdPtrR;
      end
      case ({pushOk, popOk})
        2'b10:   countNext = countR + CNT_WIDTH'(1);
        2'b01:   countNext = countR - CNT_WIDTH'(1);
        default: countNext = countR;
      endcase
    end
  end

  // Output decode: head falls through from storage, forced to NOP when empty.
  always_comb begin
    headWord = {WORD_WIDTH{1'b0}};
    if (emptyS) begin
      headWord = {WORD_WIDTH{1'b0}};
    end else begin
      headWord = storage[rdPtrR];
    end
  end

  assign fq.full           = fullS;
  assign fq.valid_D        = ~emptyS;
  assign fq.count          = countR;
  assign fq.overflow       = overflowR;
  assign fq.instruction_D  = headWord[DATA_WIDTH-1:0];
  assign fq.pc_plus_four_D = headWord[WORD_WIDTH-1:DATA_WIDTH];
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with DEPTH = 4.
module tb_fetch_queue;
  localparam int DW = 32;
  localparam int PW = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic clock;
  logic reset_n;
  int checks;
  int failures;

  fetch_queue_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

  fetch_queue #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .fq     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.flush = 1'b0;
    bus.instruction_F = 32'h0;
    bus.pc_plus_four_F = 32'h0;
  endtask

  task automatic doReset();
    idle();
    reset_n = 1'b0;
    #3;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic pushOne(input logic [31:0] ins, input logic [31:0] pc);
    bus.push = 1'b1;
    bus.instruction_F = ins;
    bus.pc_plus_four_F = pc;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    #2;
    checks++;
    if (bus.valid_D !== 1'b0 || bus.count !== 3'd0 || bus.full !== 1'b0 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got valid=%b count=%0d full=%b ovf=%b exp 0/0/0/0",
               bus.valid_D, bus.count, bus.full, bus.overflow);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.pop = i[0];
      tick();
      checks++;
      if (bus.valid_D !== 1'b0 || bus.instruction_D !== 32'h0 || bus.count !== 3'd0 ||
          bus.full !== 1'b0 || bus.overflow !== 1'b0) begin
        failures++;
        $display("FAIL empty_idle[%0d] got valid=%b ins=%h count=%0d full=%b ovf=%b exp 0/0/0/0/0",
                 i, bus.valid_D, bus.instruction_D, bus.count, bus.full, bus.overflow);
      end
    end
    idle();
  endtask

  task automatic test_fill_drain();
    logic [31:0] expIns;
    doReset();
    for (int i = 1; i <= 4; i++) begin
      pushOne(32'h20080000 + 32'(i), 32'(4 * i));
      checks++;
      if (bus.count !== 3'(i)) begin
        failures++;
        $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus.count, i);
      end
    end
    checks++;
    if (bus.full !== 1'b1) begin
      failures++;
      $display("FAIL fill_full got=%b exp=1", bus.full);
    end
    pushOne(32'h20080005, 32'd20);
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin
      failures++;
      $display("FAIL fill_overflow got ovf=%b count=%0d exp ovf=1 count=4", bus.overflow, bus.count);
    end
    for (int i = 1; i <= 4; i++) begin
      expIns = 32'h20080000 + 32'(i);
      checks++;
      if (bus.valid_D !== 1'b1 || bus.instruction_D !== expIns || bus.pc_plus_four_D !== 32'(4 * i)) begin
        failures++;
        $display("FAIL drain_head[%0d] got valid=%b ins=%h pc=%0d exp 1/%h/%0d",
                 i, bus.valid_D, bus.instruction_D, bus.pc_plus_four_D, expIns, 4 * i);
      end
      bus.pop = 1'b1;
      tick();
      idle();
    end
    checks++;
    if (bus.valid_D !== 1'b0 || bus.instruction_D !== 32'h0 || bus.pc_plus_four_D !== 32'h0 || bus.count !== 3'd0) begin
      failures++;
      $display("FAIL drain_empty got valid=%b ins=%h pc=%h count=%0d exp 0/0/0/0",
               bus.valid_D, bus.instruction_D, bus.pc_plus_four_D, bus.count);
    end
  endtask

  task automatic test_streaming();
    doReset();
    bus.push = 1'b1;
    bus.pop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.instruction_F = 32'(i);
      bus.pc_plus_four_F = 32'(4 * i + 4);
      tick();
      checks++;
      if (bus.count !== 3'd1 || bus.valid_D !== 1'b1 || bus.instruction_D !== 32'(i) ||
          bus.pc_plus_four_D !== 32'(4 * i + 4)) begin
        failures++;
        $display("FAIL stream[%0d] got count=%0d valid=%b ins=%h pc=%0d exp 1/1/%h/%0d",
                 i, bus.count, bus.valid_D, bus.instruction_D, bus.pc_plus_four_D, i, 4 * i + 4);
      end
    end
    idle();
  endtask

  task automatic test_flush();
    doReset();
    pushOne(32'h11111111, 32'd4);
    pushOne(32'h22222222, 32'd8);
    pushOne(32'h33333333, 32'd12);
    checks++;
    if (bus.count !== 3'd3) begin
      failures++;
      $display("FAIL flush_pre_count got=%0d exp=3", bus.count);
    end
    bus.flush = 1'b1;
    bus.pop = 1'b1;
    bus.push = 1'b1;
    bus.instruction_F = 32'hDEADBEEF;
    bus.pc_plus_four_F = 32'd16;
    tick();
    idle();
    checks++;
    if (bus.count !== 3'd0 || bus.valid_D !== 1'b0 || bus.instruction_D !== 32'h0) begin
      failures++;
      $display("FAIL flush_clear got count=%0d valid=%b ins=%h exp 0/0/0", bus.count, bus.valid_D, bus.instruction_D);
    end
    pushOne(32'h00000020, 32'd36);
    checks++;
    if (bus.count !== 3'd1 || bus.valid_D !== 1'b1 || bus.instruction_D !== 32'h00000020 || bus.pc_plus_four_D !== 32'd36) begin
      failures++;
      $display("FAIL flush_repush got count=%0d valid=%b ins=%h pc=%0d exp 1/1/00000020/36",
               bus.count, bus.valid_D, bus.instruction_D, bus.pc_plus_four_D);
    end
    bus.pop = 1'b1;
    tick();
    idle();
    checks++;
    if (bus.valid_D !== 1'b0 || bus.instruction_D !== 32'h0) begin
      failures++;
      $display("FAIL flush_after_pop got valid=%b ins=%h exp 0/0", bus.valid_D, bus.instruction_D);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] expIns;
    doReset();
    for (int i = 1; i <= 4; i++) pushOne(32'hA0000000 + 32'(i), 32'(4 * i));
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 3'd4) begin
      failures++;
      $display("FAIL fullpop_pre got full=%b count=%0d exp 1/4", bus.full, bus.count);
    end
    bus.push = 1'b1;
    bus.pop = 1'b1;
    bus.instruction_F = 32'hA0000099;
    bus.pc_plus_four_F = 32'd99;
    tick();
    idle();
    checks++;
    if (bus.count !== 3'd3 || bus.full !== 1'b0 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL fullpop_post got count=%0d full=%b ovf=%b exp 3/0/0", bus.count, bus.full, bus.overflow);
    end
    for (int i = 2; i <= 4; i++) begin
      expIns = 32'hA0000000 + 32'(i);
      checks++;
      if (bus.instruction_D !== expIns || bus.valid_D !== 1'b1) begin
        failures++;
        $display("FAIL fullpop_drain[%0d] got valid=%b ins=%h exp 1/%h", i, bus.valid_D, bus.instruction_D, expIns);
      end
      bus.pop = 1'b1;
      tick();
      idle();
    end
    checks++;
    if (bus.valid_D !== 1'b0 || bus.count !== 3'd0) begin
      failures++;
      $display("FAIL fullpop_empty got valid=%b count=%0d exp 0/0", bus.valid_D, bus.count);
    end
  endtask

  task automatic test_async_reset();
    doReset();
    pushOne(32'h55555555, 32'd4);
    pushOne(32'h66666666, 32'd8);
    checks++;
    if (bus.count !== 3'd2) begin
      failures++;
      $display("FAIL async_pre_count got=%0d exp=2", bus.count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.valid_D !== 1'b0 || bus.count !== 3'd0 || bus.overflow !== 1'b0 || bus.instruction_D !== 32'h0) begin
      failures++;
      $display("FAIL async_reset got valid=%b count=%0d ovf=%b ins=%h exp 0/0/0/0",
               bus.valid_D, bus.count, bus.overflow, bus.instruction_D);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b1;
    idle();
    test_reset();
    test_fill_drain();
    test_streaming();
    test_flush();
    test_full_pop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
